dzcpu_useq: RTL and testbench
=============================

DZCPU_USEQ -- requirements
Module: dzcpu_useq

Interface
REQ-001 SHALL have parameter UOP_W, default 13, microinstruction word width.
REQ-002 SHALL have parameter JCB_OP, default 5'h1F, op-field code meaning "jump via CB table".
REQ-003 SHALL have port iClock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iMop, input, 8, opcode/operand byte on memory read bus.
REQ-006 SHALL have port iMemReady, input, 1, iMop valid this cycle.
REQ-007 SHALL have port iStall, input, 1, datapath stall; freezes sequencer.
REQ-008 SHALL have port iFlagZ, input, 1, current Z flag.
REQ-009 SHALL have port oLutMop, output, 8, byte presented to opcode and CB lookup tables.
REQ-010 SHALL have port iLutIdx, input, 8, flow start index from main opcode table.
REQ-011 SHALL have port iCbLutIdx, input, 8, flow start index from CB table.
REQ-012 SHALL have port oUopAddr, output, 8, microcode ROM address (uPC).
REQ-013 SHALL have port iUop, input, UOP_W, ROM word: [12:9] flow, [8:4] op, [3:0] operand.
REQ-014 SHALL have port oUop, output, UOP_W, microinstruction issued to datapath.
REQ-015 SHALL have port oUopValid, output, 1, oUop valid and must be executed.
REQ-016 SHALL have port oPcInc, output, 1, one-cycle PC increment request.
REQ-017 SHALL have port oFlagsUpdate, output, 1, commit ALU flags this cycle.
REQ-018 SHALL have port oEof, output, 1, one-cycle end-of-flow (instruction retire) pulse.
REQ-019 SHALL have port oRetired, output, 16, retired-instruction counter.

Function
REQ-020 SHALL implement states FETCH, EXEC; reset state FETCH.
REQ-021 Flow codes SHALL be: 0 op, 1 inc, 2 eof, 3 inc_eof, 4 eof_fu, 5 inc_eof_fu, 6 inc_eof_z, 7 inc_eof_nz, 8 update_flags, 9-15 treated as op.
REQ-022 FETCH: oUopValid=0, oPcInc=0; oLutMop=iMop; when iMemReady=1 and iStall=0, uPC<=iLutIdx, opcode register<=iMop, state<=EXEC next cycle.
REQ-023 FETCH with iMemReady=0 SHALL hold state and uPC.
REQ-024 EXEC: oUopAddr=uPC; oUop=iUop combinationally; oUopValid=1 when iStall=0.
REQ-025 oPcInc SHALL be 1 in EXEC, iStall=0, for flow codes 1,3,5,6,7.
REQ-026 oFlagsUpdate SHALL be 1 in EXEC, iStall=0, for flow codes 4,5,8.
REQ-027 End-of-flow SHALL occur for codes 2,3,4,5 always, 6 when iFlagZ=1, 7 when iFlagZ=0; oEof=1 that cycle, state<=FETCH, oRetired+=1.
REQ-028 Non-eof uop in EXEC SHALL advance uPC by 1 (8-bit, 255 wraps to 0).
REQ-029 Conditional codes 6/7 with condition false SHALL issue op and advance uPC, no eof.
REQ-030 op field == JCB_OP (non-eof flow) SHALL load uPC<=iCbLutIdx with oLutMop=iMop that cycle, instead of +1; oUopValid still 1.
REQ-031 iStall=1 SHALL hold uPC, state, counter; force oUopValid, oPcInc, oFlagsUpdate, oEof to 0.
REQ-032 oLutMop in EXEC SHALL be iMop (CB byte arrives then); outside a jcb cycle it is ignored.
REQ-033 oRetired SHALL wrap 16'hFFFF -> 0.
REQ-034 No flow SHALL exceed 256 uops; runaway flows are not detected.

Reset
REQ-035 iReset low SHALL immediately force state FETCH, uPC 0, opcode register 0, oRetired 0, oUopValid/oPcInc/oFlagsUpdate/oEof 0, regardless of clock.
REQ-036 Reset asserted mid-flow SHALL abandon the flow; first post-reset action is a FETCH.

Verification
REQ-037 NOP: iMop=00, iLutIdx=162, iUop flow 3 -> one EXEC cycle, oPcInc=1, oEof=1, oRetired 0->1, back to FETCH.
REQ-038 4-uop flow at 5 (flows 1,1,0,3) -> oUopAddr 5,6,7,8 on consecutive cycles; oPcInc pattern 1,1,0,1; oEof only on 4th.
REQ-039 JRNZ at 17, uop 19 flow 6: iFlagZ=1 -> eof at uPC 19, 3 uops issued; iFlagZ=0 -> continues to 22, eof on flow 2.
REQ-040 CB: flow 13-15, uop 15 op=JCB_OP, iMop=7C, iCbLutIdx=16 -> next oUopAddr=16; uop 16 flow 4 -> oFlagsUpdate=1, oEof=1.
REQ-041 iStall=1 for 3 cycles at uPC 50 -> oUopAddr stays 50, all strobes 0; resumes at 51 after release.
REQ-042 iReset low during uPC 54 -> outputs 0 asynchronously; after release, FETCH, oRetired=0.

Source files
------------

// File: rtl/dzcpu_useq.sv
// -----------------------------------------------------------------------------
// dzcpu_useq -- microcode sequencer for the DZCPU core.
//
// Two-state sequencer. In FETCH it waits for an opcode byte on the memory bus,
// looks up the flow start address through the opcode table, and enters EXEC.
// In EXEC it issues one microinstruction per unstalled cycle. The flow field of
// each ROM word decides whether PC increments, flags commit, or the flow ends.
//
// Ports
//   iClock       : clock, rising-edge active
//   iReset       : asynchronous active-low reset
//   iMop         : opcode / operand byte from memory
//   iMemReady    : iMop valid this cycle
//   iStall       : datapath stall, freezes the sequencer and gates all strobes
//   iFlagZ       : current Z flag, used by the conditional end-of-flow codes
//   oLutMop      : byte presented to the opcode and CB lookup tables
//   iLutIdx      : flow start index from the main opcode table
//   iCbLutIdx    : flow start index from the CB table
//   oUopAddr     : microcode ROM address (uPC)
//   iUop         : ROM word {flow[12:9], op[8:4], operand[3:0]}
//   oUop         : microinstruction issued to the datapath
//   oUopValid    : oUop must be executed this cycle
//   oPcInc       : PC increment request
//   oFlagsUpdate : commit ALU flags this cycle
//   oEof         : end-of-flow (instruction retire) pulse
//   oRetired     : retired-instruction counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module dzcpu_useq #(
  parameter int         UOP_W  = 13,
  parameter logic [4:0] JCB_OP = 5'h1F
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMop,
  input  logic             iMemReady,
  input  logic             iStall,
  input  logic             iFlagZ,
  output logic [7:0]       oLutMop,
  input  logic [7:0]       iLutIdx,
  input  logic [7:0]       iCbLutIdx,
  output logic [7:0]       oUopAddr,
  input  logic [UOP_W-1:0] iUop,
  output logic [UOP_W-1:0] oUop,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagsUpdate,
  output logic             oEof,
  output logic [15:0]      oRetired
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t      r_state;
  logic [7:0]  r_upc;
  logic [7:0]  r_opcode;
  logic [15:0] r_retired;

  logic [3:0]  w_flow;
  logic [4:0]  w_op;
  logic        w_run;
  logic        w_pc_inc;
  logic        w_flags_upd;
  logic        w_eof;
  logic        w_jcb;
  logic        w_unused_opcode;

  assign w_flow = iUop[12:9];
  assign w_op   = iUop[8:4];

  // An unstalled EXEC cycle is the only time a uop is issued or state moves.
  assign w_run = (r_state == S_EXEC) && !iStall;

  // Flow-field decode; codes 9-15 behave like a plain op.
  always_comb begin
    w_pc_inc    = 1'b0;
    w_flags_upd = 1'b0;
    w_eof       = 1'b0;
    case (w_flow)
      4'd1: w_pc_inc = 1'b1;
      4'd2: w_eof = 1'b1;
      4'd3: begin w_pc_inc = 1'b1; w_eof = 1'b1; end
      4'd4: begin w_flags_upd = 1'b1; w_eof = 1'b1; end
      4'd5: begin w_pc_inc = 1'b1; w_flags_upd = 1'b1; w_eof = 1'b1; end
      4'd6: begin w_pc_inc = 1'b1; w_eof = iFlagZ; end
      4'd7: begin w_pc_inc = 1'b1; w_eof = !iFlagZ; end
      4'd8: w_flags_upd = 1'b1;
      default: ;
    endcase
  end

  // A CB jump only takes effect on a uop that does not also end the flow.
  assign w_jcb = (w_op == JCB_OP) && !w_eof;

  // The table byte is always the live bus byte: the opcode in FETCH, the CB
  // byte in a jcb cycle; in any other EXEC cycle the tables' answer is unused.
  assign oLutMop      = iMop;
  assign oUopAddr     = r_upc;
  assign oUop         = iUop;
  assign oUopValid    = w_run;
  assign oPcInc       = w_run && w_pc_inc;
  assign oFlagsUpdate = w_run && w_flags_upd;
  assign oEof         = w_run && w_eof;
  assign oRetired     = r_retired;

  // Latched opcode is kept for debug taps; nothing in the sequencer reads it.
  assign w_unused_opcode = ^r_opcode;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state   <= S_FETCH;
      r_upc     <= 8'd0;
      r_opcode  <= 8'd0;
      r_retired <= 16'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (iMemReady && !iStall) begin
            r_upc    <= iLutIdx;
            r_opcode <= iMop;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!iStall) begin
            if (w_eof) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 16'd1;
            end else if (w_jcb) begin
              r_upc <= iCbLutIdx;
            end else begin
              r_upc <= r_upc + 8'd1;
            end
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// -----------------------------------------------------------------------------
// tb_dzcpu_useq -- scoreboard bench for dzcpu_useq.
// The bench models the microcode ROM and both lookup tables. Each directed
// instruction pushes its hand-computed issue sequence into a queue; the monitor
// pops one entry for every cycle the DUT presents oUopValid.
// -----------------------------------------------------------------------------
module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [7:0]  iMop;
  logic        iMemReady;
  logic        iStall;
  logic        iFlagZ;
  logic [7:0]  oLutMop;
  logic [7:0]  iLutIdx;
  logic [7:0]  iCbLutIdx;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic [12:0] oUop;
  logic        oUopValid;
  logic        oPcInc;
  logic        oFlagsUpdate;
  logic        oEof;
  logic [15:0] oRetired;

  always #5 iClock = ~iClock;

  dzcpu_useq #(.UOP_W(13), .JCB_OP(5'h1F)) dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMemReady(iMemReady),
    .iStall(iStall), .iFlagZ(iFlagZ), .oLutMop(oLutMop), .iLutIdx(iLutIdx),
    .iCbLutIdx(iCbLutIdx), .oUopAddr(oUopAddr), .iUop(iUop), .oUop(oUop),
    .oUopValid(oUopValid), .oPcInc(oPcInc), .oFlagsUpdate(oFlagsUpdate),
    .oEof(oEof), .oRetired(oRetired)
  );

  // ROM and lookup tables
  logic [12:0] rom   [256];
  logic [7:0]  lut   [256];
  logic [7:0]  cblut [256];

  assign iUop      = rom[oUopAddr];
  assign iLutIdx   = lut[oLutMop];
  assign iCbLutIdx = cblut[oLutMop];

  function automatic logic [12:0] mk(input int flow, input int op);
    logic [3:0] f;
    logic [4:0] o;
    f = flow[3:0];
    o = op[4:0];
    return {f, o, 4'd0};
  endfunction

  typedef struct {
    logic [7:0]  addr;
    logic        pc;
    logic        fu;
    logic        eof;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_uop(input int addr, input bit pc, input bit fu,
                            input bit eof, input int ret);
    exp_t e;
    e.addr = addr[7:0];
    e.pc   = pc;
    e.fu   = fu;
    e.eof  = eof;
    e.ret  = ret[15:0];
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one pop per issued uop
  always @(negedge iClock) begin
    if (iReset && oUopValid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_uop: got addr %0d expected no issue", oUopAddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("uop_addr",  int'(oUopAddr),     int'(e.addr));
        check("uop_word",  int'(oUop),         int'(rom[e.addr]));
        check("pc_inc",    int'(oPcInc),       int'(e.pc));
        check("flags_upd", int'(oFlagsUpdate), int'(e.fu));
        check("eof",       int'(oEof),         int'(e.eof));
        check("retired",   int'(oRetired),     int'(e.ret));
        $display("uop addr=%0d pc=%0b fu=%0b eof=%0b ret=%0d",
                 oUopAddr, oPcInc, oFlagsUpdate, oEof, oRetired);
      end
    end
  end

  task automatic fetch(input logic [7:0] op, input logic [7:0] nxt);
    @(posedge iClock); #1;
    iMop = op;
    iMemReady = 1'b1;
    @(posedge iClock); #1;
    iMemReady = 1'b0;
    iMop = nxt;
  endtask

  task automatic wait_eof(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iClock);
      if (oEof) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_eof_timeout"}, 0, 1);
    @(posedge iClock); #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, int'(oUopValid),    0);
    check({name, "_pcinc"}, int'(oPcInc),       0);
    check({name, "_fu"},    int'(oFlagsUpdate), 0);
    check({name, "_eof"},   int'(oEof),         0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]   = 13'd0;
      lut[i]   = 8'd0;
      cblut[i] = 8'd0;
    end
    // NOP
    lut[8'h00] = 8'd162; rom[162] = mk(3, 0);
    // 4-uop flow
    lut[8'h01] = 8'd5;
    rom[5] = mk(1, 0); rom[6] = mk(1, 0); rom[7] = mk(0, 0); rom[8] = mk(3, 0);
    // JRNZ-style flow
    lut[8'h20] = 8'd17;
    rom[17] = mk(1, 0); rom[18] = mk(0, 0); rom[19] = mk(6, 0);
    rom[20] = mk(0, 0); rom[21] = mk(0, 0); rom[22] = mk(2, 0);
    // CB prefix
    lut[8'hCB] = 8'd13;
    rom[13] = mk(1, 0); rom[14] = mk(0, 0); rom[15] = mk(0, 31);
    cblut[8'h7C] = 8'd16; rom[16] = mk(4, 0);
    // stall flow
    lut[8'h02] = 8'd50; rom[50] = mk(1, 0); rom[51] = mk(3, 0);
    // reset flow
    lut[8'h03] = 8'd53;
    rom[53] = mk(0, 0); rom[54] = mk(0, 0); rom[55] = mk(2, 0);
    // uPC wrap
    lut[8'h04] = 8'd255; rom[255] = mk(0, 0); rom[0] = mk(3, 0);
    // flow 7
    lut[8'h05] = 8'd30; rom[30] = mk(7, 0); rom[31] = mk(2, 0);
    // flow 8, flow 9 as op, flow 5
    lut[8'h06] = 8'd32;
    rom[32] = mk(8, 0); rom[33] = mk(9, 0); rom[34] = mk(5, 0);

    iReset = 1'b0; iMop = 8'h00; iMemReady = 1'b0; iStall = 1'b0; iFlagZ = 1'b0;
    #1;
    check_idle("reset");
    check("reset_addr",    int'(oUopAddr), 0);
    check("reset_retired", int'(oRetired), 0);
    @(posedge iClock); #1;
    iReset = 1'b1;
    // idle FETCH: nothing issued for a few cycles
    repeat (3) @(posedge iClock);
    #1;
    check("idle_addr", int'(oUopAddr), 0);

    // NOP
    expect_uop(162, 1, 0, 1, 0);
    fetch(8'h00, 8'h00); wait_eof("nop");

    // 4-uop flow
    expect_uop(5, 1, 0, 0, 1); expect_uop(6, 1, 0, 0, 1);
    expect_uop(7, 0, 0, 0, 1); expect_uop(8, 1, 0, 1, 1);
    fetch(8'h01, 8'h00); wait_eof("flow4");

    // JRNZ, Z=1: ends at 19
    iFlagZ = 1'b1;
    expect_uop(17, 1, 0, 0, 2); expect_uop(18, 0, 0, 0, 2);
    expect_uop(19, 1, 0, 1, 2);
    fetch(8'h20, 8'h00); wait_eof("jrnz_z1");

    // JRNZ, Z=0: runs on to 22
    iFlagZ = 1'b0;
    expect_uop(17, 1, 0, 0, 3); expect_uop(18, 0, 0, 0, 3);
    expect_uop(19, 1, 0, 0, 3); expect_uop(20, 0, 0, 0, 3);
    expect_uop(21, 0, 0, 0, 3); expect_uop(22, 0, 0, 1, 3);
    fetch(8'h20, 8'h00); wait_eof("jrnz_z0");

    // CB prefix jump
    expect_uop(13, 1, 0, 0, 4); expect_uop(14, 0, 0, 0, 4);
    expect_uop(15, 0, 0, 0, 4); expect_uop(16, 0, 1, 1, 4);
    fetch(8'hCB, 8'h7C); wait_eof("cb");

    // stall at uPC 50
    expect_uop(50, 1, 0, 0, 5); expect_uop(51, 1, 0, 1, 5);
    fetch(8'h02, 8'h00);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClock);
      check("stall_addr", int'(oUopAddr), 50);
      check_idle("stall");
      @(posedge iClock); #1;
    end
    iStall = 1'b0;
    wait_eof("stall");

    // flow 7 with Z=1: condition false, continues
    iFlagZ = 1'b1;
    expect_uop(30, 1, 0, 0, 6); expect_uop(31, 0, 0, 1, 6);
    fetch(8'h05, 8'h00); wait_eof("flow7");
    iFlagZ = 1'b0;

    // flow 8, flow 9, flow 5
    expect_uop(32, 0, 1, 0, 7); expect_uop(33, 0, 0, 0, 7);
    expect_uop(34, 1, 1, 1, 7);
    fetch(8'h06, 8'h00); wait_eof("flow8");

    // uPC wrap 255 -> 0
    expect_uop(255, 0, 0, 0, 8); expect_uop(0, 1, 0, 1, 8);
    fetch(8'h04, 8'h00); wait_eof("wrap");

    // reset mid-flow at uPC 54
    expect_uop(53, 0, 0, 0, 9);
    fetch(8'h03, 8'h00);
    @(posedge iClock); #1;
    check("pre_reset_addr", int'(oUopAddr), 54);
    iReset = 1'b0;
    #1;
    check_idle("midreset");
    check("midreset_addr",    int'(oUopAddr), 0);
    check("midreset_retired", int'(oRetired), 0);
    @(posedge iClock); @(posedge iClock); #1;
    iReset = 1'b1;
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge iClock);
    #1;

    // first instruction after reset
    expect_uop(162, 1, 0, 1, 0);
    fetch(8'h00, 8'h00); wait_eof("post_reset_nop");
    check("final_retired", int'(oRetired), 1);
    check("final_queue",   exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
